// File: rtl/teclado_pin.sv
// Keypad front end: collects a two-digit BCD PIN, sends it to the gate controller and waits for its verdict.
// Optional build macro TECLADO_TIMEOUT_EN adds a response timeout of TIMEOUT_CICLOS cycles in ESPERA.
module teclado_pin #(
   parameter int unsigned TIMEOUT_CICLOS = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] Tecla,
   input  logic       TeclaValida,
   input  logic       Abierto,
   input  logic       Alarma,
   input  logic       Bloqueo,
   output logic [7:0] Pin,
   output logic       enterPin,
   output logic       Ocupado,
   output logic [1:0] Digitos,
   output logic       ErrorTecla,
   output logic [1:0] estado_o
);

   typedef enum logic [1:0] {
      CAPTURA   = 2'd0,
      ENVIO     = 2'd1,
      ESPERA    = 2'd2,
      BLOQUEADO = 2'd3
   } estado_t;

   if (TIMEOUT_CICLOS < 2 || TIMEOUT_CICLOS > 255) begin : g_rango_timeout
      $error("teclado_pin: TIMEOUT_CICLOS must be in 2..255");
   end

   estado_t    estado_q, estado_d;
   logic [7:0] buf_q, buf_d;
   logic [1:0] dig_q, dig_d;
   logic [7:0] pin_q, pin_d;
   logic       err_q, err_d;
   logic       valida_q;
   logic       valida_rst_q;
   logic       pulsacion;

   // A strobe still high across the last reset edge is masked once, so it never counts as a press.
   assign pulsacion = TeclaValida && !valida_q && !valida_rst_q;

`ifdef TECLADO_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
`endif

   always_comb begin
      estado_d = estado_q;
      buf_d    = buf_q;
      dig_d    = dig_q;
      pin_d    = pin_q;
      err_d    = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      cnt_d    = 8'd0;
`endif
      case (estado_q)
         CAPTURA: begin
            if (Bloqueo) begin
               estado_d = BLOQUEADO;
               buf_d    = 8'h00;
               dig_d    = 2'd0;
            end else if (pulsacion) begin
               if (Tecla <= 4'd9) begin
                  if (dig_q < 2'd2) begin
                     if (dig_q == 2'd0) buf_d[7:4] = Tecla;
                     else               buf_d[3:0] = Tecla;
                     dig_d = dig_q + 2'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (Tecla == 4'hA) begin
                  buf_d = 8'h00;
                  dig_d = 2'd0;
               end else if (Tecla == 4'hB) begin
                  if (dig_q == 2'd2) begin
                     estado_d = ENVIO;
                     pin_d    = buf_q;
                     buf_d    = 8'h00;
                     dig_d    = 2'd0;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ENVIO: estado_d = ESPERA;
         ESPERA: begin
            // Lock has priority over any verdict arriving in the same cycle.
            if (Bloqueo) begin
               estado_d = BLOQUEADO;
            end else if (Abierto || Alarma) begin
               estado_d = CAPTURA;
`ifdef TECLADO_TIMEOUT_EN
            end else if (cnt_q == 8'(TIMEOUT_CICLOS - 1)) begin
               estado_d = CAPTURA;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
`endif
            end
         end
         BLOQUEADO: begin
            if (!Bloqueo) begin
               estado_d = CAPTURA;
               buf_d    = 8'h00;
               dig_d    = 2'd0;
            end
         end
         default: estado_d = CAPTURA;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         estado_q     <= CAPTURA;
         buf_q        <= 8'h00;
         dig_q        <= 2'd0;
         pin_q        <= 8'h00;
         err_q        <= 1'b0;
         valida_q     <= 1'b0;
         valida_rst_q <= TeclaValida;
`ifdef TECLADO_TIMEOUT_EN
         cnt_q        <= 8'd0;
`endif
      end else begin
         estado_q     <= estado_d;
         buf_q        <= buf_d;
         dig_q        <= dig_d;
         pin_q        <= pin_d;
         err_q        <= err_d;
         valida_q     <= TeclaValida;
         valida_rst_q <= 1'b0;
`ifdef TECLADO_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign Pin        = pin_q;
   assign enterPin   = (estado_q == ENVIO);
   assign Ocupado    = (estado_q != CAPTURA);
   assign Digitos    = dig_q;
   assign ErrorTecla = err_q;
   assign estado_o   = estado_q;

endmodule

// File: tb/tb_teclado_pin.sv
// Directed bench for teclado_pin: each task drives one scenario and checks against hand-computed values.
module tb_teclado_pin;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] Tecla = 4'h0;
   logic       TeclaValida = 1'b0;
   logic       Abierto = 1'b0;
   logic       Alarma = 1'b0;
   logic       Bloqueo = 1'b0;
   logic [7:0] Pin;
   logic       enterPin;
   logic       Ocupado;
   logic [1:0] Digitos;
   logic       ErrorTecla;
   logic [1:0] estado_o;

   int n_cmp = 0;
   int n_err = 0;

   teclado_pin #(.TIMEOUT_CICLOS(16)) dut (
      .Clk(Clk), .Reset(Reset), .Tecla(Tecla), .TeclaValida(TeclaValida),
      .Abierto(Abierto), .Alarma(Alarma), .Bloqueo(Bloqueo),
      .Pin(Pin), .enterPin(enterPin), .Ocupado(Ocupado), .Digitos(Digitos),
      .ErrorTecla(ErrorTecla), .estado_o(estado_o)
   );

   always #5 Clk = ~Clk;

   // Strobe high for exactly one rising edge; returns on the negedge after that edge.
   task automatic press(input logic [3:0] k);
      @(negedge Clk);
      Tecla = k;
      TeclaValida = 1'b1;
      @(negedge Clk);
      TeclaValida = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge Clk);
      Reset = 1'b1; TeclaValida = 1'b1; Tecla = 4'h5;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      n_cmp++; if (Pin !== 8'h00) begin n_err++; $display("FAIL reset_pin got %h exp 00", Pin); end
      n_cmp++; if (enterPin !== 1'b0) begin n_err++; $display("FAIL reset_enter got %b exp 0", enterPin); end
      n_cmp++; if (Ocupado !== 1'b0) begin n_err++; $display("FAIL reset_ocupado got %b exp 0", Ocupado); end
      n_cmp++; if (Digitos !== 2'd0) begin n_err++; $display("FAIL reset_digitos got %0d exp 0", Digitos); end
      n_cmp++; if (ErrorTecla !== 1'b0) begin n_err++; $display("FAIL reset_error got %b exp 0", ErrorTecla); end
      n_cmp++; if (estado_o !== 2'd0) begin n_err++; $display("FAIL reset_estado got %0d exp 0", estado_o); end
      @(negedge Clk);
      @(negedge Clk);
      n_cmp++; if (Digitos !== 2'd0) begin n_err++; $display("FAIL held_through_reset got %0d exp 0", Digitos); end
      TeclaValida = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_envio();
      press(4'h4);
      n_cmp++; if (Digitos !== 2'd1) begin n_err++; $display("FAIL envio_dig1 got %0d exp 1", Digitos); end
      press(4'h2);
      n_cmp++; if (Digitos !== 2'd2) begin n_err++; $display("FAIL envio_dig2 got %0d exp 2", Digitos); end
      press(4'hB);
      n_cmp++; if (enterPin !== 1'b1) begin n_err++; $display("FAIL envio_enter got %b exp 1", enterPin); end
      n_cmp++; if (Pin !== 8'h42) begin n_err++; $display("FAIL envio_pin got %h exp 42", Pin); end
      n_cmp++; if (Ocupado !== 1'b1) begin n_err++; $display("FAIL envio_ocupado got %b exp 1", Ocupado); end
      n_cmp++; if (Digitos !== 2'd0) begin n_err++; $display("FAIL envio_digitos got %0d exp 0", Digitos); end
      @(negedge Clk);
      n_cmp++; if (enterPin !== 1'b0) begin n_err++; $display("FAIL envio_enter_drop got %b exp 0", enterPin); end
      n_cmp++; if (estado_o !== 2'd2) begin n_err++; $display("FAIL envio_espera got %0d exp 2", estado_o); end
      n_cmp++; if (Pin !== 8'h42) begin n_err++; $display("FAIL envio_pin_hold got %h exp 42", Pin); end
   endtask

   task automatic test_abierto();
      press(4'h5);
      n_cmp++; if (ErrorTecla !== 1'b0 || Digitos !== 2'd0) begin
         n_err++; $display("FAIL espera_key_ignored got err=%b dig=%0d exp err=0 dig=0", ErrorTecla, Digitos);
      end
      @(negedge Clk);
      Abierto = 1'b1;
      @(negedge Clk);
      Abierto = 1'b0;
      n_cmp++; if (Ocupado !== 1'b0) begin n_err++; $display("FAIL abierto_ocupado got %b exp 0", Ocupado); end
      press(4'h7);
      n_cmp++; if (Digitos !== 2'd1) begin n_err++; $display("FAIL abierto_dig got %0d exp 1", Digitos); end
      press(4'hA);
      n_cmp++; if (Digitos !== 2'd0 || ErrorTecla !== 1'b0) begin
         n_err++; $display("FAIL borrar got dig=%0d err=%b exp dig=0 err=0", Digitos, ErrorTecla);
      end
   endtask

   task automatic test_errores();
      @(negedge Clk);
      Abierto = 1'b1; Alarma = 1'b1;
      @(negedge Clk);
      Abierto = 1'b0; Alarma = 1'b0;
      n_cmp++; if (estado_o !== 2'd0) begin n_err++; $display("FAIL resp_in_captura got %0d exp 0", estado_o); end
      press(4'h1);
      press(4'hB);
      n_cmp++; if (ErrorTecla !== 1'b1 || enterPin !== 1'b0 || Digitos !== 2'd1) begin
         n_err++; $display("FAIL enviar_short got err=%b ent=%b dig=%0d exp 1 0 1", ErrorTecla, enterPin, Digitos);
      end
      @(negedge Clk);
      n_cmp++; if (ErrorTecla !== 1'b0) begin n_err++; $display("FAIL error_one_cycle got %b exp 0", ErrorTecla); end
      press(4'hE);
      n_cmp++; if (ErrorTecla !== 1'b1 || Digitos !== 2'd1) begin
         n_err++; $display("FAIL invalid_key got err=%b dig=%0d exp 1 1", ErrorTecla, Digitos);
      end
      press(4'hA);
      n_cmp++; if (Digitos !== 2'd0) begin n_err++; $display("FAIL borrar2 got %0d exp 0", Digitos); end
      press(4'h3);
      press(4'h8);
      press(4'h9);
      n_cmp++; if (ErrorTecla !== 1'b1 || Digitos !== 2'd2) begin
         n_err++; $display("FAIL third_digit got err=%b dig=%0d exp 1 2", ErrorTecla, Digitos);
      end
      press(4'hB);
      n_cmp++; if (Pin !== 8'h38 || enterPin !== 1'b1) begin
         n_err++; $display("FAIL third_ignored_pin got %h ent=%b exp 38 1", Pin, enterPin);
      end
      @(negedge Clk);
      Alarma = 1'b1;
      @(negedge Clk);
      Alarma = 1'b0;
      n_cmp++; if (Ocupado !== 1'b0) begin n_err++; $display("FAIL alarma_ocupado got %b exp 0", Ocupado); end
   endtask

   task automatic test_bloqueo();
      press(4'h9);
      press(4'h9);
      press(4'hB);
      n_cmp++; if (Pin !== 8'h99) begin n_err++; $display("FAIL bloq_pin got %h exp 99", Pin); end
      @(negedge Clk);
      Alarma = 1'b1; Bloqueo = 1'b1;
      @(negedge Clk);
      Alarma = 1'b0;
      n_cmp++; if (estado_o !== 2'd3 || Ocupado !== 1'b1) begin
         n_err++; $display("FAIL bloq_priority got st=%0d oc=%b exp 3 1", estado_o, Ocupado);
      end
      press(4'h3);
      n_cmp++; if (Digitos !== 2'd0 || ErrorTecla !== 1'b0 || Ocupado !== 1'b1) begin
         n_err++; $display("FAIL bloq_key got dig=%0d err=%b oc=%b exp 0 0 1", Digitos, ErrorTecla, Ocupado);
      end
      Bloqueo = 1'b0;
      @(negedge Clk);
      n_cmp++; if (estado_o !== 2'd0 || Ocupado !== 1'b0 || Digitos !== 2'd0) begin
         n_err++; $display("FAIL bloq_release got st=%0d oc=%b dig=%0d exp 0 0 0", estado_o, Ocupado, Digitos);
      end
      press(4'h6);
      @(negedge Clk);
      Bloqueo = 1'b1;
      @(negedge Clk);
      Bloqueo = 1'b0;
      n_cmp++; if (estado_o !== 2'd3 || Digitos !== 2'd0) begin
         n_err++; $display("FAIL bloq_captura got st=%0d dig=%0d exp 3 0", estado_o, Digitos);
      end
      @(negedge Clk);
      n_cmp++; if (estado_o !== 2'd0) begin n_err++; $display("FAIL bloq_captura_exit got %0d exp 0", estado_o); end
   endtask

   task automatic test_timeout();
      press(4'h1);
      press(4'h2);
      press(4'hB);
`ifdef TECLADO_TIMEOUT_EN
      repeat (16) @(negedge Clk);
      n_cmp++; if (Ocupado !== 1'b1) begin n_err++; $display("FAIL timeout_early got %b exp 1", Ocupado); end
      @(negedge Clk);
      n_cmp++; if (Ocupado !== 1'b0 || ErrorTecla !== 1'b1) begin
         n_err++; $display("FAIL timeout_fire got oc=%b err=%b exp 0 1", Ocupado, ErrorTecla);
      end
`else
      repeat (20) @(negedge Clk);
      n_cmp++; if (Ocupado !== 1'b1 || ErrorTecla !== 1'b0) begin
         n_err++; $display("FAIL no_timeout got oc=%b err=%b exp 1 0", Ocupado, ErrorTecla);
      end
      Abierto = 1'b1;
      @(negedge Clk);
      Abierto = 1'b0;
`endif
   endtask

   task automatic test_held_and_reset();
      @(negedge Clk);
      Tecla = 4'h5; TeclaValida = 1'b1;
      repeat (10) @(negedge Clk);
      TeclaValida = 1'b0;
      n_cmp++; if (Digitos !== 2'd1) begin n_err++; $display("FAIL held_key got %0d exp 1", Digitos); end
      press(4'h5);
      press(4'hB);
      n_cmp++; if (enterPin !== 1'b1 || Pin !== 8'h55) begin
         n_err++; $display("FAIL pre_reset_send got ent=%b pin=%h exp 1 55", enterPin, Pin);
      end
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      n_cmp++; if (enterPin !== 1'b0 || Pin !== 8'h00 || Ocupado !== 1'b0 || estado_o !== 2'd0) begin
         n_err++; $display("FAIL reset_in_envio got ent=%b pin=%h oc=%b st=%0d exp 0 00 0 0",
                           enterPin, Pin, Ocupado, estado_o);
      end
   endtask

   initial begin
      test_reset();
      test_envio();
      test_abierto();
      test_errores();
      test_bloqueo();
      test_timeout();
      test_held_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/teclado_pin.md
TECLADO_PIN -- requirements
Module: teclado_pin

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 16, response-wait limit in Clk cycles (range 2..255).
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 SHALL have port Tecla  input  4  keypad code; 0-9 digit, 4'hA borrar (clear), 4'hB enviar (send), 4'hC-4'hF invalid.
REQ-005 SHALL have port TeclaValida  input  1  keypad strobe; Tecla is sampled only on its 0->1 edge.
REQ-006 SHALL have port Abierto  input  1  controller response: gate opened (PIN accepted).
REQ-007 SHALL have port Alarma  input  1  controller response: wrong PIN.
REQ-008 SHALL have port Bloqueo  input  1  controller response: terminal locked.
REQ-009 SHALL have port Pin  output  8  assembled PIN, {first digit, second digit}, BCD.
REQ-010 SHALL have port enterPin  output  1  one-cycle strobe; Pin is valid on the same cycle.
REQ-011 SHALL have port Ocupado  output  1  high while waiting for a controller response or locked.
REQ-012 SHALL have port Digitos  output  2  number of digits buffered (0, 1, 2).
REQ-013 SHALL have port ErrorTecla  output  1  one-cycle pulse on rejected key press.

Function
REQ-014 SHALL detect key press as TeclaValida=1 now and 0 on previous cycle (registered); held strobe yields one press.
REQ-015 SHALL implement states CAPTURA, ENVIO, ESPERA, BLOQUEADO.
REQ-016 CAPTURA: digit with Digitos<2 -> store in next nibble slot, Digitos+1, next cycle.
REQ-017 CAPTURA: digit with Digitos=2 -> ignored, ErrorTecla pulse; buffer unchanged.
REQ-018 CAPTURA: borrar -> Digitos=0, buffer zeroed; no ErrorTecla.
REQ-019 CAPTURA: enviar with Digitos=2 -> ENVIO; enviar with Digitos<2 -> ErrorTecla pulse, stay.
REQ-020 CAPTURA: codes C-F -> ErrorTecla pulse, no other effect.
REQ-021 ENVIO: lasts exactly one cycle; enterPin=1, Pin=buffer; next state ESPERA; Digitos cleared.
REQ-022 Pin SHALL hold last sent value until next ENVIO or Reset; enterPin high only in ENVIO.
REQ-023 ESPERA: Ocupado=1; all key presses ignored (no ErrorTecla).
REQ-024 ESPERA: Bloqueo=1 -> BLOQUEADO (priority over Abierto/Alarma same cycle).
REQ-025 ESPERA: Abierto=1 or Alarma=1 (Bloqueo=0) -> CAPTURA next cycle.
REQ-026 BLOQUEADO: Ocupado=1, keys ignored; Bloqueo=0 sampled -> CAPTURA with empty buffer.
REQ-027 Bloqueo=1 in CAPTURA SHALL also force BLOQUEADO and clear buffer.
REQ-028 Response inputs asserted outside ESPERA (other than Bloqueo) SHALL be ignored.

Reset
REQ-029 Reset=1 SHALL within one edge force state CAPTURA, Pin=8'h00, enterPin=0, Ocupado=0, Digitos=0, ErrorTecla=0, edge register=0, timeout counter=0.
REQ-030 Reset SHALL override every state, including mid-ENVIO (enterPin drops next edge) and BLOQUEADO.
REQ-031 A TeclaValida already high when Reset releases SHALL NOT count as a press.

Configuration
REQ-032 Macro TECLADO_TIMEOUT_EN defined: ESPERA counts cycles from entry; on reaching TIMEOUT_CICLOS with no response -> CAPTURA and ErrorTecla pulse; counter cleared on leaving ESPERA.
REQ-033 Macro TECLADO_TIMEOUT_EN undefined: no counter logic; ESPERA waits indefinitely; TIMEOUT_CICLOS unused.

Verification
REQ-034 Reset, press 4, 2, enviar -> one cycle enterPin=1 with Pin=8'h42, Ocupado=1, Digitos=0.
REQ-035 In ESPERA assert Abierto 1 cycle -> Ocupado=0 next cycle; press 7 -> Digitos=1.
REQ-036 Press 1, enviar -> ErrorTecla pulse, no enterPin; press E -> ErrorTecla; borrar -> Digitos=0.
REQ-037 Send 8'h99, assert Alarma and Bloqueo same cycle -> BLOQUEADO, keys ignored; Bloqueo=0 -> CAPTURA, Digitos=0.
REQ-038 With TECLADO_TIMEOUT_EN, TIMEOUT_CICLOS=16, send PIN, no response -> Ocupado falls after 16 cycles in ESPERA with ErrorTecla pulse; without macro, Ocupado stays 1.
REQ-039 Hold TeclaValida=1 with Tecla=5 for 10 cycles -> Digitos=1 only; Reset during ENVIO -> Pin=8'h00, enterPin=0.
